load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width.
REQ-002 Parameter SPLIT_MISALIGN, default 1: 1 = split word-crossing accesses into two bus beats; 0 = reject them with error.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  1; req_ready  out  1  request handshake.
REQ-006 req_store  in  1; req_funct3  in  3; req_addr  in  ADDR_W; req_wdata  in  32; req_rd  in  5  request payload (RV32 load/store encoding).
REQ-007 bus_req  out  1; bus_we  out  1; bus_addr  out  ADDR_W (word-aligned); bus_be  out  4; bus_wdata  out  32  bus request.
REQ-008 bus_ack  in  1; bus_rdata  in  32  bus completion, rdata valid with ack.
REQ-009 resp_valid  out  1; resp_rd  out  5; resp_data  out  32; resp_err  out  1  response pulse.
REQ-010 busy  out  1  high whenever state != IDLE.

Function
REQ-011 FSM states IDLE, BEAT0, BEAT1, RESP; req_ready = 1 only in IDLE.
REQ-012 Accept on req_valid & req_ready; payload captured; IDLE -> BEAT0 (or RESP if rejected).
REQ-013 Legal funct3: loads 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000 sb, 001 sh, 010 sw; any other -> rejected, resp_err = 1, no bus beat.
REQ-014 Offset o = addr[1:0]; access crosses word iff o + size > 4 (size 1/2/4 bytes).
REQ-015 Crossing with SPLIT_MISALIGN = 0 -> rejected, resp_err = 1, no bus beat.
REQ-016 bus_req asserted throughout BEAT0/BEAT1; bus_we, bus_addr, bus_be, bus_wdata held stable while bus_req high and bus_ack low.
REQ-017 BEAT0: bus_addr = {addr[ADDR_W-1:2], 2'b00}, bus_be = byte mask of size bytes shifted left o, truncated to 4 bits.
REQ-018 BEAT0 & bus_ack: crossing -> BEAT1, else -> RESP.
REQ-019 BEAT1: bus_addr = BEAT0 address + 4, modulo 2^ADDR_W (wrap at top of space); bus_be = upper 4 bits of 8-bit shifted mask.
REQ-020 Stores: 64-bit lane vector = wdata zero-extended, shifted left 8*o; bits [31:0] on BEAT0, [63:32] on BEAT1; bus_we = 1.
REQ-021 Loads: bus_we = 0; BEAT0 rdata into low word, BEAT1 rdata into high word of 64-bit buffer; result = buffer >> 8*o, then sign-extend (lb/lh) or zero-extend (lbu/lhu) from size.
REQ-022 RESP lasts exactly one cycle: resp_valid = 1, resp_rd = captured rd (0 for stores), resp_data = load result (0 for stores/errors); then -> IDLE.
REQ-023 resp_rd, resp_data, resp_err are 0 whenever resp_valid = 0.
REQ-024 Latency, aligned, ack in first bus cycle: accept edge N, bus_req cycle N+1, resp_valid cycle N+2; each extra ack-wait cycle adds one; split adds one beat.
REQ-025 bus_ack outside BEAT0/BEAT1 is ignored.
REQ-026 No new request accepted in the cycle resp_valid is high (back-to-back throughput one access per 3 cycles minimum).

Reset
REQ-027 rst high at a rising edge -> state IDLE, buffers cleared; next cycle req_ready = 1, busy = 0, bus_req = 0, resp_valid = 0, all other outputs 0.
REQ-028 rst mid-transaction abandons it: no resp_valid produced; a bus_ack arriving after reset is ignored.

Verification
REQ-029 lw addr 0x100, ack same cycle, rdata 0xDEADBEEF -> one beat, be 1111, resp_valid at N+2, resp_data 0xDEADBEEF.
REQ-030 lb addr 0x103, rdata 0x80FFFFFF -> be 1000, resp_data 0xFFFFFF80; lbu same -> 0x00000080.
REQ-031 SPLIT_MISALIGN=1, sw addr 0x202, wdata 0x11223344 -> beat0 addr 0x200 be 1100 wdata 0x33440000, beat1 addr 0x204 be 0011 wdata 0x00001122, resp_rd 0.
REQ-032 SPLIT_MISALIGN=1, lhu addr 0xFFFFFFFF, rdata 0xAB000000 then 0x000000CD -> beat1 addr 0x00000000 (wrap), resp_data 0x0000CDAB.
REQ-033 SPLIT_MISALIGN=0, lw addr 0x101 -> no bus_req, resp_err 1 at N+1; funct3 011 load -> same.
REQ-034 Ack delayed 3 cycles, rst asserted in 2nd wait cycle -> bus_req low after edge, no resp_valid, req_ready 1 next cycle.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32 load/store unit: one request at a time, word-aligned bus beats,
// word-crossing accesses either split into two beats or rejected.
module load_store_unit #(
    parameter int ADDR_W         = 32,
    parameter bit SPLIT_MISALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    output logic              resp_valid,
    output logic [4:0]        resp_rd,
    output logic [31:0]       resp_data,
    output logic              resp_err,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t state_reg, state_next;

    logic              store_reg;
    logic [2:0]        funct3_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [4:0]        rd_reg;
    logic              err_reg;
    logic              cross_reg;
    logic [7:0]        mask_reg;
    logic [63:0]       lanes_reg;
    logic [63:0]       buf_reg;

    logic        accept;
    logic        req_legal;
    logic [2:0]  req_size;
    logic [7:0]  req_base;
    logic        req_cross;
    logic        req_reject;

    assign accept = req_valid && (state_reg == IDLE);

    always_comb begin
        req_legal = 1'b0;
        case ({req_store, req_funct3})
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
            4'b1000, 4'b1001, 4'b1010: req_legal = 1'b1;
            default:                   req_legal = 1'b0;
        endcase
        case (req_funct3[1:0])
            2'b00:   begin req_size = 3'd1; req_base = 8'h01; end
            2'b01:   begin req_size = 3'd2; req_base = 8'h03; end
            default: begin req_size = 3'd4; req_base = 8'h0F; end
        endcase
        req_cross  = ({1'b0, req_addr[1:0]} + req_size) > 3'd4;
        req_reject = !req_legal || (req_cross && !SPLIT_MISALIGN);
    end

    // Byte mask and store lanes are precomputed at accept as 8-byte windows;
    // BEAT0 drives the low half, BEAT1 the high half.
    always_ff @(posedge clk) begin
        if (rst) begin
            store_reg  <= 1'b0;
            funct3_reg <= 3'b000;
            addr_reg   <= '0;
            rd_reg     <= 5'd0;
            err_reg    <= 1'b0;
            cross_reg  <= 1'b0;
            mask_reg   <= 8'h00;
            lanes_reg  <= 64'd0;
            buf_reg    <= 64'd0;
        end else begin
            if (accept) begin
                store_reg  <= req_store;
                funct3_reg <= req_funct3;
                addr_reg   <= req_addr;
                rd_reg     <= req_rd;
                err_reg    <= req_reject;
                cross_reg  <= req_cross;
                mask_reg   <= req_base << req_addr[1:0];
                lanes_reg  <= req_store ? ({32'd0, req_wdata} << {req_addr[1:0], 3'b000}) : 64'd0;
                buf_reg    <= 64'd0;
            end
            if (state_reg == BEAT0 && bus_ack) buf_reg[31:0]  <= bus_rdata;
            if (state_reg == BEAT1 && bus_ack) buf_reg[63:32] <= bus_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = req_reject ? RESP : BEAT0;
            BEAT0:   if (bus_ack) state_next = cross_reg ? BEAT1 : RESP;
            BEAT1:   if (bus_ack) state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    // Load alignment: shift the two-word buffer down by the byte offset, then
    // fill bytes beyond the access size with zero or the sign bit.
    logic [31:0] shifted;
    logic [31:0] load_result;
    logic [2:0]  load_size;
    logic        load_fill;

    assign shifted = 32'(buf_reg >> {addr_reg[1:0], 3'b000});

    always_comb begin
        case (funct3_reg[1:0])
            2'b00:   begin load_size = 3'd1; load_fill = !funct3_reg[2] && shifted[7];  end
            2'b01:   begin load_size = 3'd2; load_fill = !funct3_reg[2] && shifted[15]; end
            default: begin load_size = 3'd4; load_fill = 1'b0;                          end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_load_byte
            assign load_result[8*gi +: 8] = (3'(gi) < load_size) ? shifted[8*gi +: 8] : {8{load_fill}};
        end
    endgenerate

    logic [ADDR_W-1:0] beat_base;
    assign beat_base = {addr_reg[ADDR_W-1:2], 2'b00};

    always_comb begin
        req_ready  = (state_reg == IDLE);
        busy       = (state_reg != IDLE);
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = '0;
        bus_be     = 4'h0;
        bus_wdata  = 32'd0;
        resp_valid = 1'b0;
        resp_rd    = 5'd0;
        resp_data  = 32'd0;
        resp_err   = 1'b0;
        case (state_reg)
            BEAT0: begin
                bus_req   = 1'b1;
                bus_we    = store_reg;
                bus_addr  = beat_base;
                bus_be    = mask_reg[3:0];
                bus_wdata = lanes_reg[31:0];
            end
            BEAT1: begin
                bus_req   = 1'b1;
                bus_we    = store_reg;
                bus_addr  = beat_base + ADDR_W'(4);
                bus_be    = mask_reg[7:4];
                bus_wdata = lanes_reg[63:32];
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_reg;
                resp_rd    = store_reg ? 5'd0 : rd_reg;
                resp_data  = (store_reg || err_reg) ? 32'd0 : load_result;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table of accesses driven through a bus model,
// responses checked against a scoreboard queue, plus reset and reject sequences.
module tb_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_valid0;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        bus_ack, bus_ack0;
    logic [31:0] bus_rdata;

    logic        req_ready, bus_req, bus_we, resp_valid, resp_err, busy;
    logic [31:0] bus_addr, bus_wdata, resp_data;
    logic [3:0]  bus_be;
    logic [4:0]  resp_rd;

    logic        req_ready0, bus_req0, bus_we0, resp_valid0, resp_err0, busy0;
    logic [31:0] bus_addr0, bus_wdata0, resp_data0;
    logic [3:0]  bus_be0;
    logic [4:0]  resp_rd0;

    load_store_unit #(.ADDR_W(32), .SPLIT_MISALIGN(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .resp_valid(resp_valid), .resp_rd(resp_rd),
        .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
    );

    load_store_unit #(.ADDR_W(32), .SPLIT_MISALIGN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .bus_req(bus_req0), .bus_we(bus_we0),
        .bus_addr(bus_addr0), .bus_be(bus_be0), .bus_wdata(bus_wdata0), .bus_ack(bus_ack0),
        .bus_rdata(bus_rdata), .resp_valid(resp_valid0), .resp_rd(resp_rd0),
        .resp_data(resp_data0), .resp_err(resp_err0), .busy(busy0)
    );

    typedef struct {
        logic        store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        int          dly;
        logic [31:0] r0;
        logic [31:0] r1;
        int          nb;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [3:0]  be0;
        logic [3:0]  be1;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] edata;
        logic [4:0]  erd;
        logic        eerr;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t sb_q[$];
    resp_t mon_e;
    int    total = 0;
    int    bad   = 0;
    bit    mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (resp_valid === 1'b1) begin
                chk("ready_during_resp", 64'(req_ready), 64'd0);
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got rd=%0d data=0x%08h err=%0b expected none",
                             resp_rd, resp_data, resp_err);
                end else begin
                    mon_e = sb_q.pop_front();
                    $display("resp rd=%0d data=0x%08h err=%0b (want rd=%0d data=0x%08h err=%0b)",
                             resp_rd, resp_data, resp_err, mon_e.rd, mon_e.data, mon_e.err);
                    chk("resp_rd", 64'(resp_rd), 64'(mon_e.rd));
                    chk("resp_data", 64'(resp_data), 64'(mon_e.data));
                    chk("resp_err", 64'(resp_err), 64'(mon_e.err));
                end
            end else begin
                chk("resp_zero_when_idle", 64'({resp_valid, resp_rd, resp_data, resp_err}), 64'd0);
            end
        end
    end

    task automatic wait_ready();
        int guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_timeout", 64'(req_ready), 64'd1);
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] ea, ew;
        logic [3:0]  eb;
        wait_ready();
        req_store  = v.store;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_rd     = v.rd;
        req_valid  = 1'b1;
        sb_q.push_back('{v.erd, v.edata, v.eerr});
        @(negedge clk);
        req_valid = 1'b0;
        if (v.nb == 0) begin
            chk("reject_no_bus", 64'(bus_req), 64'd0);
        end
        for (int b = 0; b < v.nb; b++) begin
            ea = (b == 0) ? v.a0 : v.a1;
            eb = (b == 0) ? v.be0 : v.be1;
            ew = (b == 0) ? v.w0 : v.w1;
            for (int w = 0; w <= v.dly; w++) begin
                $display("beat %0d addr=0x%08h be=%04b we=%0b wdata=0x%08h", b, bus_addr, bus_be, bus_we, bus_wdata);
                chk("bus_req", 64'(bus_req), 64'd1);
                chk("busy", 64'(busy), 64'd1);
                chk("bus_we", 64'(bus_we), 64'(v.store));
                chk("bus_addr", 64'(bus_addr), 64'(ea));
                chk("bus_be", 64'(bus_be), 64'(eb));
                if (v.store) chk("bus_wdata", 64'(bus_wdata), 64'(ew));
                if (w == v.dly) begin
                    bus_ack   = 1'b1;
                    bus_rdata = (b == 0) ? v.r0 : v.r1;
                end
                @(negedge clk);
                bus_ack   = 1'b0;
                bus_rdata = 32'd0;
            end
        end
        chk("resp_latency", 64'(resp_valid), 64'd1);
    endtask

    task automatic rej0(input logic st, input logic [2:0] f3, input logic [31:0] addr);
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = 32'h11223344;
        req_rd     = 5'd3;
        chk("dut0_ready", 64'(req_ready0), 64'd1);
        req_valid0 = 1'b1;
        @(negedge clk);
        req_valid0 = 1'b0;
        $display("dut0 reject addr=0x%08h f3=%03b resp_valid=%0b err=%0b", addr, f3, resp_valid0, resp_err0);
        chk("dut0_no_bus", 64'(bus_req0), 64'd0);
        chk("dut0_resp_valid", 64'(resp_valid0), 64'd1);
        chk("dut0_resp_err", 64'(resp_err0), 64'd1);
        chk("dut0_resp_data", 64'(resp_data0), 64'd0);
        @(negedge clk);
        chk("dut0_back_idle", 64'({resp_valid0, req_ready0}), 64'b01);
    endtask

    vec_t vt[12];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 0, 32'hDEADBEEF, 32'h0, 1,
                   32'h100, 32'h0, 4'hF, 4'h0, 32'h0, 32'h0, 32'hDEADBEEF, 5'd5, 1'b0};
        vt[1]  = '{1'b0, 3'b000, 32'h103, 32'h0, 5'd6, 1, 32'h80FFFFFF, 32'h0, 1,
                   32'h100, 32'h0, 4'h8, 4'h0, 32'h0, 32'h0, 32'hFFFFFF80, 5'd6, 1'b0};
        vt[2]  = '{1'b0, 3'b100, 32'h103, 32'h0, 5'd7, 0, 32'h80FFFFFF, 32'h0, 1,
                   32'h100, 32'h0, 4'h8, 4'h0, 32'h0, 32'h0, 32'h00000080, 5'd7, 1'b0};
        vt[3]  = '{1'b1, 3'b010, 32'h202, 32'h11223344, 5'd7, 0, 32'h0, 32'h0, 2,
                   32'h200, 32'h204, 4'hC, 4'h3, 32'h33440000, 32'h00001122, 32'h0, 5'd0, 1'b0};
        vt[4]  = '{1'b0, 3'b101, 32'hFFFFFFFF, 32'h0, 5'd8, 1, 32'hAB000000, 32'h000000CD, 2,
                   32'hFFFFFFFC, 32'h0, 4'h8, 4'h1, 32'h0, 32'h0, 32'h0000CDAB, 5'd8, 1'b0};
        vt[5]  = '{1'b0, 3'b001, 32'h002, 32'h0, 5'd9, 2, 32'h80011234, 32'h0, 1,
                   32'h0, 32'h0, 4'hC, 4'h0, 32'h0, 32'h0, 32'hFFFF8001, 5'd9, 1'b0};
        vt[6]  = '{1'b1, 3'b000, 32'h001, 32'h123456A5, 5'd10, 1, 32'h0, 32'h0, 1,
                   32'h0, 32'h0, 4'h2, 4'h0, 32'h3456A500, 32'h0, 32'h0, 5'd0, 1'b0};
        vt[7]  = '{1'b0, 3'b010, 32'h0FE, 32'h0, 5'd11, 0, 32'h56781111, 32'h22221234, 2,
                   32'h0FC, 32'h100, 4'hC, 4'h3, 32'h0, 32'h0, 32'h12345678, 5'd11, 1'b0};
        vt[8]  = '{1'b0, 3'b011, 32'h040, 32'h0, 5'd12, 0, 32'h0, 32'h0, 0,
                   32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 5'd12, 1'b1};
        vt[9]  = '{1'b1, 3'b100, 32'h044, 32'hFFFFFFFF, 5'd13, 0, 32'h0, 32'h0, 0,
                   32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1};
        vt[10] = '{1'b0, 3'b001, 32'h003, 32'h0, 5'd14, 3, 32'hFF000000, 32'h00000001, 2,
                   32'h0, 32'h4, 4'h8, 4'h1, 32'h0, 32'h0, 32'h000001FF, 5'd14, 1'b0};
        vt[11] = '{1'b1, 3'b001, 32'h000, 32'hAAAABBBB, 5'd15, 0, 32'h0, 32'h0, 1,
                   32'h0, 32'h0, 4'h3, 4'h0, 32'hAAAABBBB, 32'h0, 32'h0, 5'd0, 1'b0};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_valid0 = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_rd     = 5'd0;
        bus_ack    = 1'b0;
        bus_ack0   = 1'b0;
        bus_rdata  = 32'd0;
        @(negedge clk);
        @(negedge clk);
        $display("reset ready=%0b busy=%0b bus_req=%0b resp_valid=%0b", req_ready, busy, bus_req, resp_valid);
        chk("reset_ready", 64'(req_ready), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_bus", 64'({bus_req, bus_we, bus_be}), 64'd0);
        chk("reset_bus_addr", 64'(bus_addr), 64'd0);
        chk("reset_bus_wdata", 64'(bus_wdata), 64'd0);
        chk("reset_resp", 64'({resp_valid, resp_rd, resp_err}), 64'd0);
        chk("reset_resp_data", 64'(resp_data), 64'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vt[i]);

        // Reset during the second ack-wait cycle abandons the access.
        wait_ready();
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h100;
        req_rd     = 5'd20;
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_wait1_bus_req", 64'(bus_req), 64'd1);
        @(negedge clk);
        chk("abort_wait2_bus_req", 64'(bus_req), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("abort bus_req=%0b busy=%0b ready=%0b", bus_req, busy, req_ready);
        chk("abort_bus_req", 64'(bus_req), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ready", 64'(req_ready), 64'd1);
        bus_ack   = 1'b1;
        bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;
        chk("late_ack_ignored", 64'({busy, bus_req}), 64'd0);
        repeat (3) @(negedge clk);

        // Non-splitting instance rejects crossing and illegal accesses.
        rej0(1'b0, 3'b010, 32'h101);
        rej0(1'b0, 3'b011, 32'h100);
        rej0(1'b1, 3'b010, 32'h202);

        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h100;
        req_rd     = 5'd4;
        req_valid0 = 1'b1;
        @(negedge clk);
        req_valid0 = 1'b0;
        chk("dut0_aligned_bus_req", 64'(bus_req0), 64'd1);
        chk("dut0_aligned_be", 64'(bus_be0), 64'hF);
        bus_ack0  = 1'b1;
        bus_rdata = 32'h0BADF00D;
        @(negedge clk);
        bus_ack0  = 1'b0;
        bus_rdata = 32'd0;
        $display("dut0 aligned lw resp_valid=%0b data=0x%08h", resp_valid0, resp_data0);
        chk("dut0_aligned_resp", 64'({resp_valid0, resp_err0, resp_rd0}), 64'({1'b1, 1'b0, 5'd4}));
        chk("dut0_aligned_data", 64'(resp_data0), 64'h0BADF00D);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
